// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared Mini-MIPS definitions: load type codes, GPR indexing,
//               and sign/zero extension helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int GPR_IDX_W = 5;

    typedef logic [GPR_IDX_W-1:0] gpr_idx_t;

    localparam gpr_idx_t REGISTER_RZERO = 5'd0;

    // Load width/extension selector; codes 5..7 fall back to a full word.
    typedef enum logic [2:0] {
        LOAD_LW  = 3'd0,
        LOAD_LB  = 3'd1,
        LOAD_LBU = 3'd2,
        LOAD_LH  = 3'd3,
        LOAD_LHU = 3'd4
    } load_type_e;

    function automatic logic [31:0] extend8(input logic [7:0] value, input logic is_signed);
        return {{24{is_signed & value[7]}}, value};
    endfunction

    function automatic logic [31:0] extend16(input logic [15:0] value, input logic is_signed);
        return {{16{is_signed & value[15]}}, value};
    endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage_if
// Description : Memory-stage to writeback-stage bundle plus the register file
//               write port and debug outputs driven by the stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface writeback_stage_if
    import mips_pkg::*;
#(
    parameter int RETIRE_W = 32
);
    logic                stall;
    logic                flush;
    logic                in_valid;
    logic                in_reg_write;
    logic                in_mem_to_reg;
    logic [2:0]          in_load_type;
    logic [1:0]          in_byte_offset;
    gpr_idx_t            in_dest_reg;
    logic [31:0]         in_alu_result;
    logic [31:0]         in_mem_data;
    gpr_idx_t            write_reg;
    logic [31:0]         write_data;
    logic                write_enable;
    logic                wb_valid;
    logic [RETIRE_W-1:0] retired_count;

    // Upstream side: memory stage / hazard unit.
    modport master (
        output stall, flush, in_valid, in_reg_write, in_mem_to_reg, in_load_type,
               in_byte_offset, in_dest_reg, in_alu_result, in_mem_data,
        input  write_reg, write_data, write_enable, wb_valid, retired_count
    );

    // The writeback stage itself.
    modport slave (
        input  stall, flush, in_valid, in_reg_write, in_mem_to_reg, in_load_type,
               in_byte_offset, in_dest_reg, in_alu_result, in_mem_data,
        output write_reg, write_data, write_enable, wb_valid, retired_count
    );
endinterface
`default_nettype wire

// File: rtl/writeback_stage_load_extract.sv
`default_nettype none
// ============================================================================
// Module      : load_extract
// Description : Combinational byte/halfword lane select and sign/zero extension
//               of a raw aligned memory word.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extract
    import mips_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] mem_word,
    input  logic [1:0]  byte_offset,
    input  logic [2:0]  load_type,
    output logic [31:0] load_value
);
    logic [1:0]  w_byte_lane;
    logic        w_half_upper;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane numbers count from bits[7:0]; big-endian mirrors the offset.
    assign w_byte_lane  = BIG_ENDIAN ? ~byte_offset : byte_offset;
    assign w_half_upper = BIG_ENDIAN ? ~byte_offset[1] : byte_offset[1];
    assign w_byte       = mem_word[{w_byte_lane, 3'b000} +: 8];
    assign w_half       = w_half_upper ? mem_word[31:16] : mem_word[15:0];

    // Width select and extension; unknown codes behave as a full-word load.
    always_comb begin
        load_value = mem_word;
        case (load_type)
            LOAD_LB:  load_value = extend8(w_byte, 1'b1);
            LOAD_LBU: load_value = extend8(w_byte, 1'b0);
            LOAD_LH:  load_value = extend16(w_half, 1'b1);
            LOAD_LHU: load_value = extend16(w_half, 1'b0);
            default:  load_value = mem_word;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : MEM/WB pipeline register, writeback mux and retired-instruction
//               counter; drives the register file write port, which commits on
//               the negedge of the cycle the stage holds the instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage
    import mips_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int RETIRE_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    writeback_stage_if.slave wb
);
    localparam logic [RETIRE_W-1:0] c_retire_one = {{(RETIRE_W-1){1'b0}}, 1'b1};

    logic                r_valid;
    logic                r_reg_write;
    logic                r_mem_to_reg;
    logic [2:0]          r_load_type;
    logic [1:0]          r_byte_offset;
    gpr_idx_t            r_dest_reg;
    logic [31:0]         r_alu_result;
    logic [31:0]         r_mem_data;
    logic [RETIRE_W-1:0] r_retired_count;
    logic [31:0]         w_load_value;

    // Pipeline register: reset > flush > stall > capture. Flush only drops
    // the valid bit; the data fields are irrelevant once invalid.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid         <= 1'b0;
            r_reg_write     <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_load_type     <= 3'd0;
            r_byte_offset   <= 2'd0;
            r_dest_reg      <= REGISTER_RZERO;
            r_alu_result    <= 32'd0;
            r_mem_data      <= 32'd0;
            r_retired_count <= '0;
        end else if (wb.flush) begin
            r_valid <= 1'b0;
        end else if (!wb.stall) begin
            r_valid       <= wb.in_valid;
            r_reg_write   <= wb.in_reg_write;
            r_mem_to_reg  <= wb.in_mem_to_reg;
            r_load_type   <= wb.in_load_type;
            r_byte_offset <= wb.in_byte_offset;
            r_dest_reg    <= wb.in_dest_reg;
            r_alu_result  <= wb.in_alu_result;
            r_mem_data    <= wb.in_mem_data;
            if (wb.in_valid) begin
                r_retired_count <= r_retired_count + c_retire_one;
            end
        end
    end

    load_extract #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_load_extract (
        .mem_word    (r_mem_data),
        .byte_offset (r_byte_offset),
        .load_type   (r_load_type),
        .load_value  (w_load_value)
    );

    // Write port is built from registered fields only; $zero is never written.
    assign wb.write_reg     = r_dest_reg;
    assign wb.write_data    = r_mem_to_reg ? w_load_value : r_alu_result;
    assign wb.write_enable  = r_valid & r_reg_write & (r_dest_reg != REGISTER_RZERO);
    assign wb.wb_valid      = r_valid;
    assign wb.retired_count = r_retired_count;
endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Directed self-checking bench for writeback_stage with a
//               scoreboard queue and a negedge-commit register file model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;
    import mips_pkg::*;

    localparam int RW = 4;

    typedef struct {
        logic          we;
        logic [4:0]    wreg;
        logic [31:0]   data;
        logic          vld;
        logic [RW-1:0] cnt;
        logic          fields;
    } exp_t;

    logic clock = 1'b0;
    logic reset;

    int          checks   = 0;
    int          failures = 0;
    exp_t        sb[$];
    exp_t        last_exp;
    logic [RW-1:0] exp_cnt;
    logic [31:0] rf [32];

    always #5 clock = ~clock;

    writeback_stage_if #(.RETIRE_W(RW)) be_if ();
    writeback_stage_if #(.RETIRE_W(RW)) le_if ();

    writeback_stage #(.BIG_ENDIAN(1'b1), .RETIRE_W(RW)) dut_be (
        .clock (clock),
        .reset (reset),
        .wb    (be_if.slave)
    );

    writeback_stage #(.BIG_ENDIAN(1'b0), .RETIRE_W(RW)) dut_le (
        .clock (clock),
        .reset (reset),
        .wb    (le_if.slave)
    );

    // Register file: commits the stage's write port on the negedge.
    always @(negedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (be_if.write_enable) begin
            rf[be_if.write_reg] <= be_if.write_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                          input logic [1:0] off, input logic [4:0] dst,
                          input logic [31:0] alu, input logic [31:0] mem);
        be_if.in_valid = v;        le_if.in_valid = v;
        be_if.in_reg_write = rw;   le_if.in_reg_write = rw;
        be_if.in_mem_to_reg = m2r; le_if.in_mem_to_reg = m2r;
        be_if.in_load_type = lt;   le_if.in_load_type = lt;
        be_if.in_byte_offset = off; le_if.in_byte_offset = off;
        be_if.in_dest_reg = dst;   le_if.in_dest_reg = dst;
        be_if.in_alu_result = alu; le_if.in_alu_result = alu;
        be_if.in_mem_data = mem;   le_if.in_mem_data = mem;
    endtask

    // One clock: apply controls, push the expectation, then pop and compare.
    task automatic cycle(input string tag, input logic rst_i, input logic stall_i, input logic flush_i,
                         input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic fields);
        exp_t e;
        reset = rst_i;
        be_if.stall = stall_i; le_if.stall = stall_i;
        be_if.flush = flush_i; le_if.flush = flush_i;
        if (rst_i) begin
            exp_cnt  = '0;
            e.we = 1'b0; e.wreg = 5'd0; e.data = 32'd0; e.vld = 1'b0; e.fields = 1'b1;
        end else if (flush_i) begin
            e.we = 1'b0; e.wreg = 5'd0; e.data = 32'd0; e.vld = 1'b0; e.fields = 1'b0;
        end else if (stall_i) begin
            e = last_exp;
        end else begin
            if (be_if.in_valid) exp_cnt = exp_cnt + 1'b1;
            e.we = we; e.wreg = wr; e.data = wd; e.vld = be_if.in_valid; e.fields = fields;
        end
        e.cnt    = exp_cnt;
        last_exp = e;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk({tag, ".write_enable"}, 32'(be_if.write_enable), 32'(e.we));
        chk({tag, ".wb_valid"}, 32'(be_if.wb_valid), 32'(e.vld));
        chk({tag, ".retired_count"}, 32'(be_if.retired_count), 32'(e.cnt));
        if (e.fields) begin
            chk({tag, ".write_reg"}, 32'(be_if.write_reg), 32'(e.wreg));
            chk({tag, ".write_data"}, be_if.write_data, e.data);
        end
    endtask

    initial begin
        logic [31:0] lb_exp  [4];
        logic [31:0] lbu_exp [4];
        lb_exp  = '{32'hFFFFFF80, 32'hFFFFFFFF, 32'h0000007F, 32'h00000001};
        lbu_exp = '{32'h00000080, 32'h000000FF, 32'h0000007F, 32'h00000001};
        exp_cnt = '0;
        reset = 1'b1;
        be_if.stall = 1'b0; le_if.stall = 1'b0;
        be_if.flush = 1'b0; le_if.flush = 1'b0;

        // Reset held two cycles while an instruction is presented.
        set_in(1'b1, 1'b1, 1'b0, LOAD_LW, 2'd0, 5'd9, 32'h0000AAAA, 32'h0);
        cycle("reset0", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        cycle("reset1", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);

        // ADD r5 = 0x1234
        set_in(1'b1, 1'b1, 1'b0, LOAD_LW, 2'd0, 5'd5, 32'h00001234, 32'h0);
        cycle("add_r5", 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h00001234, 1'b1);
        chk("add_r5.count_one", 32'(be_if.retired_count), 32'd1);

        // Byte loads, big-endian main DUT, little-endian spot checks.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b1, 1'b1, LOAD_LB, 2'(i), 5'd8, 32'h0, 32'h80FF7F01);
            cycle($sformatf("lb_off%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, lb_exp[i], 1'b1);
            if (i == 0) chk("lb_le_off0", le_if.write_data, 32'h00000001);
        end
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b1, 1'b1, LOAD_LBU, 2'(i), 5'd9, 32'h0, 32'h80FF7F01);
            cycle($sformatf("lbu_off%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, lbu_exp[i], 1'b1);
            if (i == 3) chk("lbu_le_off3", le_if.write_data, 32'h00000080);
        end

        // Halfword and word loads.
        set_in(1'b1, 1'b1, 1'b1, LOAD_LH, 2'd0, 5'd10, 32'h0, 32'h8001FFFE);
        cycle("lh_off0", 1'b0, 1'b0, 1'b0, 1'b1, 5'd10, 32'hFFFF8001, 1'b1);
        chk("lh_le_off0", le_if.write_data, 32'hFFFFFFFE);
        set_in(1'b1, 1'b1, 1'b1, LOAD_LHU, 2'd2, 5'd11, 32'h0, 32'h8001FFFE);
        cycle("lhu_off2", 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 32'h0000FFFE, 1'b1);
        chk("lhu_le_off2", le_if.write_data, 32'h00008001);
        set_in(1'b1, 1'b1, 1'b1, LOAD_LH, 2'd1, 5'd12, 32'h0, 32'h8001FFFE);
        cycle("lh_off1", 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'hFFFF8001, 1'b1);
        set_in(1'b1, 1'b1, 1'b1, LOAD_LW, 2'd3, 5'd13, 32'h0, 32'h8001FFFE);
        cycle("lw_off3", 1'b0, 1'b0, 1'b0, 1'b1, 5'd13, 32'h8001FFFE, 1'b1);
        set_in(1'b1, 1'b1, 1'b1, 3'd7, 2'd1, 5'd14, 32'h0, 32'h12345678);
        cycle("type7_as_lw", 1'b0, 1'b0, 1'b0, 1'b1, 5'd14, 32'h12345678, 1'b1);

        // Write to $zero is suppressed but still retires.
        set_in(1'b1, 1'b1, 1'b0, LOAD_LW, 2'd0, 5'd0, 32'hDEADBEEF, 32'h0);
        cycle("write_r0", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'hDEADBEEF, 1'b1);
        @(negedge clock);
        #1;
        chk("rf_r0_zero", rf[0], 32'd0);

        // Bubble and non-writing instruction.
        set_in(1'b0, 1'b1, 1'b0, LOAD_LW, 2'd0, 5'd7, 32'h00000001, 32'h0);
        cycle("bubble", 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h00000001, 1'b1);
        set_in(1'b1, 1'b0, 1'b0, LOAD_LW, 2'd0, 5'd6, 32'h00000055, 32'h0);
        cycle("no_regwrite", 1'b0, 1'b0, 1'b0, 1'b0, 5'd6, 32'h00000055, 1'b1);

        // Stall three cycles with changing inputs, then stall+flush.
        set_in(1'b1, 1'b1, 1'b0, LOAD_LW, 2'd0, 5'd10, 32'h00000A0A, 32'h0);
        cycle("pre_stall", 1'b0, 1'b0, 1'b0, 1'b1, 5'd10, 32'h00000A0A, 1'b1);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 1'b0, LOAD_LW, 2'd0, 5'(11 + i), 32'h0000BAD0 + 32'(i), 32'h0);
            cycle($sformatf("stall%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        end
        cycle("stall_flush", 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);

        // Write r3 = 7, then a decode read in the following cycle.
        set_in(1'b1, 1'b1, 1'b0, LOAD_LW, 2'd0, 5'd3, 32'h00000007, 32'h0);
        cycle("write_r3", 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h00000007, 1'b1);
        set_in(1'b0, 1'b0, 1'b0, LOAD_LW, 2'd0, 5'd4, 32'h0, 32'h0);
        cycle("after_r3", 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 32'h0, 1'b1);
        chk("rf_r3_decode_read", rf[3], 32'h00000007);

        // Stream to all-ones, then one more valid wraps to zero.
        for (int k = 0; k < 20 && exp_cnt != '1; k++) begin
            set_in(1'b1, 1'b0, 1'b0, LOAD_LW, 2'd0, 5'd1, 32'(k), 32'h0);
            cycle("stream", 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 32'(k), 1'b1);
        end
        chk("count_all_ones", 32'(be_if.retired_count), 32'((1 << RW) - 1));
        set_in(1'b1, 1'b1, 1'b0, LOAD_LW, 2'd0, 5'd2, 32'h00000022, 32'h0);
        cycle("wrap", 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h00000022, 1'b1);
        chk("count_wrap_zero", 32'(be_if.retired_count), 32'd0);

        // Reset asserted together with stall and flush wins.
        set_in(1'b1, 1'b1, 1'b0, LOAD_LW, 2'd0, 5'd5, 32'h00000099, 32'h0);
        cycle("pre_reset", 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h00000099, 1'b1);
        cycle("reset_stall_flush", 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
